// File: rtl/usb_pkg.sv
// Shared USB receive definitions: packet classes, PID codes and CRC constants.
// CRC checking in the decoder is enabled by defining USB_RX_CRC_CHECK_EN.
package usb_pkg;

    typedef enum logic [1:0] {
        PT_SPECIAL = 2'b00,
        PT_TOKEN   = 2'b01,
        PT_HSK     = 2'b10,
        PT_DATA    = 2'b11
    } pkt_type_e;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_POLY  = 5'h14;
    localparam logic [4:0]  CRC5_RES   = 5'h06;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_RES  = 16'hB001;

    // Upper nibble of a PID byte is the ones-complement of the lower nibble.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// Reflected (LSB-first) CRC register updated with up to 8 bits per cycle.
// Used by the decoder only when USB_RX_CRC_CHECK_EN is defined.
module usb_crc_byte #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] INIT = '1
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic         init,
    input  logic         en,
    input  logic [7:0]   data,
    input  logic [3:0]   nbits,
    output logic [W-1:0] crc
);

    logic [W-1:0] nxt;

    always_comb begin
        nxt = crc;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbits) begin
                nxt = (nxt >> 1) ^ ((nxt[0] ^ data[i]) ? POLY : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            crc <= INIT;
        end else if (init) begin
            crc <= INIT;
        end else if (en) begin
            crc <= nxt;
        end
    end

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet decoder: PID check, token fields, CRC strip, status pulse.
// Define USB_RX_CRC_CHECK_EN to compute and check CRC5/CRC16 residuals.
module usb_rx_packet_decoder
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_eop,
    input  logic       rx_error,
    output logic [3:0] pid,
    output logic [1:0] pkt_type,
    output logic [6:0] tok_addr,
    output logic [3:0] tok_endp,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic       pkt_done,
    output logic       pkt_ok,
    output logic       pid_err,
    output logic       crc_err,
    output logic       len_err
);

    typedef enum logic [2:0] {
        IDLE, TOKEN, DATA, HSK, SPECIAL, DROP
    } state_e;

    localparam int CW = $clog2(MAX_PAYLOAD + 4);
    localparam logic [CW-1:0] CMAX = CW'(MAX_PAYLOAD + 2);

    state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0] hold0, hold0_n, hold1, hold1_n;
    logic eop_q, end_pend, end_pend_n;
    logic [3:0] pid_n, tok_endp_n;
    logic [1:0] pkt_type_n;
    logic [6:0] tok_addr_n;
    logic [7:0] pay_data_n;
    logic pay_valid_n, pkt_done_n, pkt_ok_n;
    logic pid_err_n, crc_err_n, len_err_n;
    logic eop_rise, crc_init, crc_en, crc_bad, len_bad;

    assign eop_rise = rx_eop & ~eop_q;

`ifdef USB_RX_CRC_CHECK_EN
    logic [4:0]  crc5;
    logic [15:0] crc16;

    usb_crc_byte #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk   (clk),
        .nRST  (nRST),
        .init  (crc_init),
        .en    (crc_en),
        .data  (rx_data),
        .nbits (4'd8),
        .crc   (crc5)
    );

    usb_crc_byte #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk   (clk),
        .nRST  (nRST),
        .init  (crc_init),
        .en    (crc_en),
        .data  (rx_data),
        .nbits (4'd8),
        .crc   (crc16)
    );

    assign crc_bad = (state == TOKEN && crc5 != CRC5_RES)
                  || (state == DATA && crc16 != CRC16_RES);
`else
    logic unused_crc;
    assign unused_crc = ^{crc_init, crc_en};
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold0_n     = hold0;
        hold1_n     = hold1;
        end_pend_n  = end_pend;
        pid_n       = pid;
        pkt_type_n  = pkt_type;
        tok_addr_n  = tok_addr;
        tok_endp_n  = tok_endp;
        pay_data_n  = pay_data;
        pay_valid_n = 1'b0;
        pkt_done_n  = 1'b0;
        pkt_ok_n    = pkt_ok;
        pid_err_n   = pid_err;
        crc_err_n   = crc_err;
        len_err_n   = len_err;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        len_bad     = 1'b0;

        if (state == IDLE) begin
            end_pend_n = 1'b0;
            if (rx_valid) begin
                pid_err_n = 1'b0;
                crc_err_n = 1'b0;
                len_err_n = 1'b0;
                pkt_ok_n  = 1'b0;
                cnt_n     = '0;
                if (!pid_ok(rx_data)) begin
                    pid_err_n = 1'b1;
                    state_n   = DROP;
                end else begin
                    pid_n      = rx_data[3:0];
                    pkt_type_n = rx_data[1:0];
                    crc_init   = 1'b1;
                    unique case (pkt_type_e'(rx_data[1:0]))
                        PT_TOKEN:   state_n = TOKEN;
                        PT_DATA:    state_n = DATA;
                        PT_HSK:     state_n = HSK;
                        PT_SPECIAL: state_n = SPECIAL;
                    endcase
                end
            end
        end else begin
            if (rx_error) begin
                len_err_n = 1'b1;
                state_n   = DROP;
            end else if (rx_valid && !end_pend) begin
                if (cnt != CMAX) cnt_n = cnt + 1'b1;
                case (state)
                    TOKEN: begin
                        crc_en = 1'b1;
                        if (cnt == '0) begin
                            tok_addr_n    = rx_data[6:0];
                            tok_endp_n[0] = rx_data[7];
                        end else if (cnt == CW'(1)) begin
                            tok_endp_n[3:1] = rx_data[2:0];
                        end
                    end
                    DATA: begin
                        if (cnt == CMAX) begin
                            len_err_n = 1'b1;
                            state_n   = DROP;
                        end else begin
                            crc_en  = 1'b1;
                            hold0_n = rx_data;
                            hold1_n = hold0;
                            // The two newest bytes may be CRC, so only older ones leave.
                            if (cnt >= CW'(2)) begin
                                pay_data_n  = hold1;
                                pay_valid_n = 1'b1;
                            end
                        end
                    end
                    HSK: begin
                        len_err_n = 1'b1;
                        state_n   = DROP;
                    end
                    default: ;
                endcase
            end

            // A byte arriving with the EOP edge is absorbed first; verdict next cycle.
            if (eop_rise && rx_valid) begin
                end_pend_n = 1'b1;
            end else if (eop_rise || end_pend) begin
                if (state == TOKEN && cnt != CW'(2)) len_bad = 1'b1;
                if (state == DATA && cnt < CW'(2)) len_bad = 1'b1;
                len_err_n  = len_err_n | len_bad;
                crc_err_n  = crc_err_n | crc_bad;
                pkt_ok_n   = !(pid_err_n | crc_err_n | len_err_n);
                pkt_done_n = 1'b1;
                end_pend_n = 1'b0;
                state_n    = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= '0;
            hold0     <= '0;
            hold1     <= '0;
            eop_q     <= 1'b0;
            end_pend  <= 1'b0;
            pid       <= '0;
            pkt_type  <= '0;
            tok_addr  <= '0;
            tok_endp  <= '0;
            pay_data  <= '0;
            pay_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            pid_err   <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hold0     <= hold0_n;
            hold1     <= hold1_n;
            eop_q     <= rx_eop;
            end_pend  <= end_pend_n;
            pid       <= pid_n;
            pkt_type  <= pkt_type_n;
            tok_addr  <= tok_addr_n;
            tok_endp  <= tok_endp_n;
            pay_data  <= pay_data_n;
            pay_valid <= pay_valid_n;
            pkt_done  <= pkt_done_n;
            pkt_ok    <= pkt_ok_n;
            pid_err   <= pid_err_n;
            crc_err   <= crc_err_n;
            len_err   <= len_err_n;
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed bench for usb_rx_packet_decoder: vector table plus corner sequences.
// Expected crc_err follows whether USB_RX_CRC_CHECK_EN is defined.
module tb_usb_rx_packet_decoder;
    import usb_pkg::*;

`ifdef USB_RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic nRST = 1'b0;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0, rx_eop = 1'b0, rx_error = 1'b0;
    logic [3:0] pid, tok_endp;
    logic [1:0] pkt_type;
    logic [6:0] tok_addr;
    logic [7:0] pay_data;
    logic pay_valid, pkt_done, pkt_ok, pid_err, crc_err, len_err;

    usb_rx_packet_decoder dut (
        .clk(clk), .nRST(nRST), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_eop(rx_eop), .rx_error(rx_error), .pid(pid), .pkt_type(pkt_type),
        .tok_addr(tok_addr), .tok_endp(tok_endp), .pay_data(pay_data),
        .pay_valid(pay_valid), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
        .pid_err(pid_err), .crc_err(crc_err), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, done_cnt = 0;
    logic [7:0] payq[$];
    logic s_ok, s_pe, s_ce, s_le;

    always @(negedge clk) begin
        if (pay_valid) payq.push_back(pay_data);
        if (pkt_done) begin
            done_cnt <= done_cnt + 1;
            s_ok <= pkt_ok;
            s_pe <= pid_err;
            s_ce <= crc_err;
            s_le <= len_err;
        end
    end

    typedef struct {
        logic [95:0] b;
        int n;
        logic [3:0] pid;
        logic [1:0] typ;
        bit ok, pe, ce, le;
        int np;
        bit chk_pid, chk_tok, chk_crc;
        logic [6:0] addr;
        logic [3:0] endp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [95:0] b, input int n, input logic [3:0] p,
                                input logic [1:0] t, input bit ok, input bit pe,
                                input bit ce, input bit le, input int np);
        vec_t v;
        v.b = b; v.n = n; v.pid = p; v.typ = t;
        v.ok = ok; v.pe = pe; v.ce = ce; v.le = le; v.np = np;
        v.chk_pid = 1'b1; v.chk_tok = 1'b0; v.chk_crc = 1'b1;
        v.addr = '0; v.endp = '0;
        return v;
    endfunction

    // Second token byte: endpoint high bits plus transmitted (inverted) CRC5.
    function automatic logic [7:0] tok_b2(input logic [6:0] a, input logic [3:0] e);
        logic [10:0] d;
        logic [4:0] c;
        d = {e, a};
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
            else c = c >> 1;
        end
        return {~c, e[3:1]};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_eop();
        rx_eop = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_eop = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int d0;
        vecs[0] = mk({8'h2D, 8'h00, 8'h10}, 3, 4'hD, 2'b01, 1, 0, 0, 0, 0);
        vecs[0].chk_tok = 1; vecs[0].addr = 7'h00; vecs[0].endp = 4'h0;
        vecs[1] = mk({8'hE1, 8'hBA, tok_b2(7'h3A, 4'h5)}, 3, 4'h1, 2'b01, 1, 0, 0, 0, 0);
        vecs[1].chk_tok = 1; vecs[1].addr = 7'h3A; vecs[1].endp = 4'h5;
        vecs[2] = mk({8'h69, 8'hFF, tok_b2(7'h7F, 4'hF)}, 3, 4'h9, 2'b01, 1, 0, 0, 0, 0);
        vecs[2].chk_tok = 1; vecs[2].addr = 7'h7F; vecs[2].endp = 4'hF;
        vecs[3] = mk({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00,
                      8'hDD, 8'h94}, 11, 4'h3, 2'b11, 1, 0, 0, 0, 8);
        vecs[4] = mk({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00,
                      8'hDD, 8'h95}, 11, 4'h3, 2'b11, !CRC_ON, 0, CRC_ON, 0, 8);
        vecs[5] = mk({8'hD2}, 1, 4'h2, 2'b10, 1, 0, 0, 0, 0);
        vecs[6] = mk({8'hD3}, 1, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        vecs[6].chk_pid = 0;
        vecs[7] = mk({8'h2D, 8'h00}, 2, 4'hD, 2'b01, 0, 0, 0, 1, 0);
        vecs[7].chk_crc = 0;
        vecs[8] = mk({8'hC3, 8'h00, 8'h00}, 3, 4'h3, 2'b11, 1, 0, 0, 0, 0);
        vecs[9] = mk({8'hC3, 8'h00}, 2, 4'h3, 2'b11, 0, 0, 0, 1, 0);
        vecs[9].chk_crc = 0;
        vecs[10] = mk({8'hD2, 8'h55}, 2, 4'h2, 2'b10, 0, 0, 0, 1, 0);
        vecs[11] = mk({8'hB4, 8'h12, 8'h34, 8'h56}, 4, 4'h4, 2'b00, 1, 0, 0, 0, 0);
        vecs[12] = mk({8'h4B, 8'h00, 8'h00}, 3, 4'hB, 2'b11, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {pid, pkt_type, tok_addr, tok_endp, pay_data, pay_valid,
                              pkt_done, pkt_ok, pid_err, crc_err, len_err}, 0);
        nRST = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            d0 = done_cnt;
            payq.delete();
            for (int j = 0; j < vecs[i].n; j++)
                send_byte(vecs[i].b[8*(vecs[i].n-1-j) +: 8]);
            send_eop();
            chk($sformatf("v%0d done", i), done_cnt - d0, 1);
            chk($sformatf("v%0d pkt_ok", i), s_ok, vecs[i].ok);
            chk($sformatf("v%0d pid_err", i), s_pe, vecs[i].pe);
            chk($sformatf("v%0d len_err", i), s_le, vecs[i].le);
            if (vecs[i].chk_crc) chk($sformatf("v%0d crc_err", i), s_ce, vecs[i].ce);
            if (vecs[i].chk_pid) begin
                chk($sformatf("v%0d pid", i), pid, vecs[i].pid);
                chk($sformatf("v%0d pkt_type", i), pkt_type, vecs[i].typ);
            end
            if (vecs[i].chk_tok) begin
                chk($sformatf("v%0d tok_addr", i), tok_addr, vecs[i].addr);
                chk($sformatf("v%0d tok_endp", i), tok_endp, vecs[i].endp);
            end
            chk($sformatf("v%0d pay count", i), payq.size(), vecs[i].np);
            for (int k = 0; k < vecs[i].np && k < payq.size(); k++)
                chk($sformatf("v%0d pay[%0d]", i, k), payq[k],
                    vecs[i].b[8*(vecs[i].n-2-k) +: 8]);
        end

        d0 = done_cnt;
        send_eop();
        chk("idle eop no done", done_cnt - d0, 0);

        send_byte(8'h2D);
        send_byte(8'h00);
        rx_data = 8'h10; rx_valid = 1'b1; rx_eop = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("simul done early", pkt_done, 0);
        @(posedge clk); #1;
        chk("simul done", pkt_done, 1);
        chk("simul ok", pkt_ok, 1);
        rx_eop = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        d0 = done_cnt;
        payq.delete();
        send_byte(8'hC3);
        for (int i = 0; i < 67; i++) send_byte(8'(i));
        send_eop();
        chk("ovf done", done_cnt - d0, 1);
        chk("ovf len_err", s_le, 1);
        chk("ovf pkt_ok", s_ok, 0);
        chk("ovf pay count", payq.size(), 64);
        if (payq.size() > 63) chk("ovf last pay", payq[63], 8'h3F);

        d0 = done_cnt;
        payq.delete();
        send_byte(8'hC3); send_byte(8'h80); send_byte(8'h06); send_byte(8'h00);
        rx_error = 1'b1;
        @(posedge clk); #1;
        rx_error = 1'b0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        send_eop();
        chk("err done", done_cnt - d0, 1);
        chk("err len_err", s_le, 1);
        chk("err pkt_ok", s_ok, 0);
        chk("err pay count", payq.size(), 1);
        if (payq.size() > 0) chk("err pay[0]", payq[0], 8'h80);
        send_byte(8'h2D); send_byte(8'h00); send_byte(8'h10);
        send_eop();
        chk("after err ok", s_ok, 1);
        chk("after err len_err", s_le, 0);

        send_byte(8'hC3); send_byte(8'h80); send_byte(8'h06);
        send_byte(8'h00); send_byte(8'h01);
        nRST = 1'b0;
        #2;
        chk("midreset outputs", {pid, pkt_type, tok_addr, tok_endp, pay_data, pay_valid,
                                 pkt_done, pkt_ok, pid_err, crc_err, len_err}, 0);
        @(posedge clk); #1;
        nRST = 1'b1;
        d0 = done_cnt;
        send_eop();
        chk("midreset no done", done_cnt - d0, 0);
        send_byte(8'hD2);
        send_eop();
        chk("post reset done", done_cnt - d0, 1);
        chk("post reset ok", s_ok, 1);
        chk("post reset type", pkt_type, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
